// File: rtl/fifo_reader_if.sv
// Bundle of FIFO read-port and downstream valid/ready stream signals for fifo_reader.
// master = the reader; slave = the FIFO plus downstream sink.
interface fifo_reader_if #(
    parameter int unsigned WIDTH = 8
);
    logic             fifo_rd_en_o;
    logic [WIDTH-1:0] fifo_rdata_i;
    logic             fifo_empty_i;
    logic             fifo_error_i;
    logic [WIDTH-1:0] m_data_o;
    logic             m_valid_o;
    logic             m_ready_i;

    modport master (
        output fifo_rd_en_o,
        input  fifo_rdata_i,
        input  fifo_empty_i,
        input  fifo_error_i,
        output m_data_o,
        output m_valid_o,
        input  m_ready_i
    );

    modport slave (
        input  fifo_rd_en_o,
        output fifo_rdata_i,
        output fifo_empty_i,
        output fifo_error_i,
        input  m_data_o,
        input  m_valid_o,
        output m_ready_i
    );
endinterface

// File: rtl/fifo_reader.sv
// Burst reader: pulls burst_len_i words from a FIFO with 1-cycle read latency into a
// 2-entry skid buffer and streams them downstream. FIFO_READER_STATS_EN adds rd_count_o.
module fifo_reader #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned BURST_W = 5
) (
    input  logic               rd_clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [BURST_W-1:0] burst_len_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
`ifdef FIFO_READER_STATS_EN
    output logic [BURST_W-1:0] rd_count_o,
`endif
    fifo_reader_if.master      bus
);
    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic [BURST_W-1:0] len_q, len_d;
    logic [BURST_W-1:0] issued_q, issued_d;
    logic               inflight_q, inflight_d;
    logic [1:0]         occ_q, occ_d;
    logic [WIDTH-1:0]   buf0_q, buf0_d;
    logic [WIDTH-1:0]   buf1_q, buf1_d;
    logic               err_q, err_d;
    logic               start_acc, xfer, rd_en;

    assign start_acc = (state_q == StIdle) && start_i;
    assign xfer      = (occ_q != 2'd0) && bus.m_ready_i;
    // Room is counted including the word in flight; a same-cycle pop frees one slot.
    assign rd_en     = (state_q == StRun) && !bus.fifo_empty_i && (issued_q < len_q) &&
                       ((({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2) || xfer);
    assign inflight_d = rd_en;

    // Skid buffer: buf0 is the head; data returning from the FIFO is captured when in flight.
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        occ_d  = occ_q;
        case ({inflight_q, xfer})
            2'b01: begin
                if (occ_q == 2'd2) buf0_d = buf1_q;
                occ_d = occ_q - 2'd1;
            end
            2'b10: begin
                if (occ_q == 2'd0) buf0_d = bus.fifo_rdata_i;
                else               buf1_d = bus.fifo_rdata_i;
                occ_d = occ_q + 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d = bus.fifo_rdata_i;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = bus.fifo_rdata_i;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q;
        err_d    = err_q;
        if ((state_q != StIdle) && bus.fifo_error_i) err_d = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (start_acc) begin
                    len_d    = burst_len_i;
                    issued_d = '0;
                    err_d    = 1'b0;
                    state_d  = (burst_len_i == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (rd_en) issued_d = issued_q + 1'b1;
                if (issued_q == len_q) state_d = StDrain;
            end
            StDrain: begin
                // Look at next-cycle occupancy so done follows the last transfer directly.
                if ((occ_d == 2'd0) && !inflight_d) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state_q    <= StIdle;
            len_q      <= '0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            err_q      <= err_d;
        end
    end

    assign busy_o           = (state_q != StIdle);
    assign done_o           = (state_q == StDone);
    assign err_o            = err_q;
    assign bus.fifo_rd_en_o = rd_en;
    assign bus.m_data_o     = buf0_q;
    assign bus.m_valid_o    = (occ_q != 2'd0);

`ifdef FIFO_READER_STATS_EN
    logic [BURST_W-1:0] rd_count_q, rd_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        if (start_acc)                      rd_count_d = '0;
        else if (xfer && (rd_count_q != '1)) rd_count_d = rd_count_q + 1'b1;
    end

    always_ff @(posedge rd_clk) begin
        if (rst) rd_count_q <= '0;
        else     rd_count_q <= rd_count_d;
    end

    assign rd_count_o = rd_count_q;
`endif
endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: FIFO model with 1-cycle read latency, expected words
// queued at push time and compared as the DUT streams them out.
module tb_fifo_reader;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned BW    = 5;

    logic          rd_clk = 1'b0;
    logic          rst    = 1'b1;
    logic          start_i = 1'b0;
    logic [BW-1:0] burst_len_i = '0;
    logic          busy_o, done_o, err_o;
`ifdef FIFO_READER_STATS_EN
    logic [BW-1:0] rd_count_o;
`endif

    fifo_reader_if #(.WIDTH(WIDTH)) bus ();

    fifo_reader #(.WIDTH(WIDTH), .BURST_W(BW)) dut (
        .rd_clk      (rd_clk),
        .rst         (rst),
        .start_i     (start_i),
        .burst_len_i (burst_len_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
`ifdef FIFO_READER_STATS_EN
        .rd_count_o  (rd_count_o),
`endif
        .bus         (bus)
    );

    always #5 rd_clk = ~rd_clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int strobes, xfers, first_strobe, last_strobe, first_xfer, last_xfer;
    logic force_empty = 1'b0;
    logic [WIDTH-1:0] fifo_model[$];
    logic [WIDTH-1:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_empty();
        bus.fifo_empty_i = force_empty || (fifo_model.size() == 0);
    endtask

    // One clock: FIFO model answers a strobe seen before the edge with data after it.
    task automatic tick();
        logic rd;
        @(negedge rd_clk);
        rd = bus.fifo_rd_en_o;
        @(posedge rd_clk);
        cyc++;
        #1;
        if (rd && (fifo_model.size() != 0)) bus.fifo_rdata_i = fifo_model.pop_front();
        drive_empty();
    endtask

    task automatic clr_stats();
        strobes = 0; xfers = 0;
        first_strobe = -1; last_strobe = -1; first_xfer = -1; last_xfer = -1;
    endtask

    task automatic push_words(input logic [WIDTH-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_model.push_back(base + WIDTH'(i));
            sb.push_back(base + WIDTH'(i));
        end
        drive_empty();
    endtask

    task automatic start_burst(input int len);
        start_i     = 1'b1;
        burst_len_i = BW'(len);
        tick();
        start_i     = 1'b0;
        burst_len_i = '0;
    endtask

    task automatic wait_done(input string tag, output int dc);
        dc = -1;
        for (int i = 0; (i < 60) && !done_o; i++) tick();
        if (done_o) dc = cyc;
        else check({tag, "_timeout"}, 32'(done_o), 32'd1);
    endtask

    always @(negedge rd_clk) begin
        if (!rst) begin
            if (bus.fifo_rd_en_o) begin
                if (strobes == 0) first_strobe = cyc;
                last_strobe = cyc;
                strobes++;
            end
            if (bus.m_valid_o) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", 32'(bus.m_valid_o), 32'd0);
                end else begin
                    check("m_data", 32'(bus.m_data_o), 32'(sb[0]));
                    if (bus.m_ready_i) begin
                        void'(sb.pop_front());
                        if (xfers == 0) first_xfer = cyc;
                        last_xfer = cyc;
                        xfers++;
                    end
                end
            end
        end
    end

    initial begin
        int s0, dc;
        bus.fifo_rdata_i = '0;
        bus.fifo_error_i = 1'b0;
        bus.m_ready_i    = 1'b0;
        drive_empty();
        clr_stats();
        tick();
        tick();
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_rd_en", 32'(bus.fifo_rd_en_o), 32'd0);
        check("rst_valid", 32'(bus.m_valid_o), 32'd0);
        check("rst_data", 32'(bus.m_data_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        rst = 1'b0;
        tick();

        // Streaming burst
        clr_stats();
        push_words(8'h11, 4);
        bus.m_ready_i = 1'b1;
        s0 = cyc;
        start_burst(4);
        wait_done("stream", dc);
        check("stream_strobes", 32'(strobes), 32'd4);
        check("stream_first_strobe", 32'(first_strobe), 32'(s0 + 1));
        check("stream_strobe_span", 32'(last_strobe - first_strobe), 32'd3);
        check("stream_xfers", 32'(xfers), 32'd4);
        check("stream_xfer_span", 32'(last_xfer - first_xfer), 32'd3);
        check("stream_done_lat", 32'(dc - last_xfer), 32'd1);
        check("stream_err", 32'(err_o), 32'd0);
        tick();
        check("stream_done_pulse", 32'(done_o), 32'd0);
        check("stream_idle", 32'(busy_o), 32'd0);

        // Backpressure
        clr_stats();
        push_words(8'h21, 3);
        bus.m_ready_i = 1'b0;
        start_burst(3);
        for (int i = 0; i < 4; i++) tick();
        check("bp_strobes_before_ready", 32'(strobes), 32'd2);
        bus.m_ready_i = 1'b1;
        wait_done("bp", dc);
        check("bp_xfers", 32'(xfers), 32'd3);
        check("bp_sb_empty", 32'(sb.size()), 32'd0);
        tick();

        // Empty mid-burst
        clr_stats();
        push_words(8'h31, 5);
        start_burst(5);
        for (int i = 0; (i < 20) && (strobes < 2); i++) tick();
        force_empty = 1'b1;
        drive_empty();
        s0 = strobes;
        for (int i = 0; i < 4; i++) tick();
        check("empty_stall_strobes", 32'(strobes), 32'(s0));
        check("empty_stall_busy", 32'(busy_o), 32'd1);
        force_empty = 1'b0;
        drive_empty();
        wait_done("empty", dc);
        check("empty_xfers", 32'(xfers), 32'd5);
        check("empty_strobes", 32'(strobes), 32'd5);
        check("empty_err", 32'(err_o), 32'd0);
        tick();

        // Zero length
        clr_stats();
        start_burst(0);
        check("zero_done", 32'(done_o), 32'd1);
        check("zero_busy", 32'(busy_o), 32'd1);
        check("zero_rd_en", 32'(bus.fifo_rd_en_o), 32'd0);
        tick();
        check("zero_done_clr", 32'(done_o), 32'd0);
        check("zero_busy_clr", 32'(busy_o), 32'd0);
        check("zero_strobes", 32'(strobes), 32'd0);

        // Sticky error
        clr_stats();
        push_words(8'h41, 3);
        start_burst(3);
        tick();
        bus.fifo_error_i = 1'b1;
        tick();
        bus.fifo_error_i = 1'b0;
        check("err_set", 32'(err_o), 32'd1);
        wait_done("err", dc);
        check("err_xfers", 32'(xfers), 32'd3);
        tick();
        check("err_sticky_idle", 32'(err_o), 32'd1);
        start_burst(0);
        check("err_clr_on_start", 32'(err_o), 32'd0);
        tick();

        // Reset mid-burst with a read in flight
        clr_stats();
        push_words(8'h51, 6);
        start_burst(6);
        tick();
        bus.fifo_error_i = 1'b1;
        tick();
        bus.fifo_error_i = 1'b0;
        rst = 1'b1;
        sb.delete();
        tick();
        fifo_model.delete();
        drive_empty();
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_done", 32'(done_o), 32'd0);
        check("mid_rst_rd_en", 32'(bus.fifo_rd_en_o), 32'd0);
        check("mid_rst_valid", 32'(bus.m_valid_o), 32'd0);
        check("mid_rst_data", 32'(bus.m_data_o), 32'd0);
        check("mid_rst_err", 32'(err_o), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_valid", 32'(bus.m_valid_o), 32'd0);
            check("post_rst_data", 32'(bus.m_data_o), 32'd0);
        end

`ifdef FIFO_READER_STATS_EN
        for (int b = 0; b < 2; b++) begin
            clr_stats();
            push_words(WIDTH'(8'h61 + 8'(b * 16)), 3);
            start_burst(3);
            wait_done("stats", dc);
            tick();
            check("stats_rd_count", 32'(rd_count_o), 32'd3);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter BURST_W, default 5, width of burst length and word counters.
REQ-003 rd_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start_i  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 burst_len_i  input  BURST_W  number of words in the burst; sampled with start_i.
REQ-007 busy_o  output  1  high in every state except IDLE.
REQ-008 done_o  output  1  one-cycle pulse when a burst completes.
REQ-009 fifo_rd_en_o  output  1  read strobe to the FIFO read port.
REQ-010 fifo_rdata_i  input  WIDTH  FIFO read data, valid the cycle after a sampled strobe.
REQ-011 fifo_empty_i  input  1  FIFO empty flag.
REQ-012 fifo_error_i  input  1  FIFO error flag (read from empty).
REQ-013 m_data_o  output  WIDTH  downstream data.
REQ-014 m_valid_o  output  1  downstream data valid.
REQ-015 m_ready_i  input  1  downstream ready; a transfer occurs when m_valid_o and m_ready_i are both high.
REQ-016 err_o  output  1  sticky error flag.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE to RUN: start_i=1 and burst_len_i!=0.
- IDLE to DONE: start_i=1 and burst_len_i=0.
- RUN to DRAIN: issued count reaches the latched length.
- DRAIN to DONE: buffer empty and no read in flight.
- DONE to IDLE: unconditional after one cycle.
REQ-018 start_i SHALL be ignored outside IDLE; burst_len_i SHALL be latched on the accepted start.
REQ-019 fifo_rd_en_o SHALL be combinational and high only when all of the following hold:
- state is RUN;
- fifo_empty_i=0;
- issued count < latched length;
- (buffer occupancy + in-flight) < 2, or a downstream transfer occurs this cycle.
REQ-020 Read timing:
- strobe sampled at edge k;
- an in-flight flag is set at edge k;
- fifo_rdata_i is captured into a 2-entry skid buffer at edge k+1, and the flag clears;
- m_valid_o rises after edge k+1.
REQ-021 With m_ready_i held high and the FIFO non-empty, the block SHALL sustain one word per cycle.
REQ-022 Output ordering and stability:
- words SHALL leave in FIFO order;
- m_data_o SHALL be held stable while m_valid_o=1 and m_ready_i=0.
REQ-023 The buffer SHALL never overflow; a capture and a transfer in the same cycle SHALL leave occupancy unchanged.
REQ-024 The issued count SHALL increment per sampled strobe and stop exactly at the latched length, with no wrap.
REQ-025 If fifo_empty_i rises mid-burst, the block SHALL stall in RUN with strobe low and resume when empty falls.
REQ-026 err_o behaviour:
- set if fifo_error_i=1 in any non-IDLE cycle;
- cleared only by rst or an accepted start;
- the burst continues regardless of err_o.
REQ-027 done_o SHALL be high only in DONE.

Reset
REQ-028 On rst=1 at a rising edge, all of the following SHALL occur:
- state goes to IDLE;
- counters and buffer are cleared;
- the in-flight flag is dropped, and data returning next cycle is discarded.
REQ-029 Reset values: busy_o=0, done_o=0, fifo_rd_en_o=0, m_valid_o=0, m_data_o=0, err_o=0.
REQ-030 rst SHALL take priority over start_i and every other input; reset mid-burst is legal.

Configuration
REQ-031 Macro FIFO_READER_STATS_EN.
- Defined: adds output rd_count_o, BURST_W bits, reset 0; counts downstream transfers, cleared on accepted start, saturating at all-ones.
- Undefined: port and logic absent; all other behaviour identical.

Verification
REQ-032 Streaming burst: FIFO holds 0x11..0x14, start with len=4, ready=1 -> strobes on 4 consecutive cycles; m_data_o 0x11,0x12,0x13,0x14 on consecutive cycles; done_o one cycle after last transfer; err_o=0.
REQ-033 Backpressure: len=3, ready=0 for 5 cycles then 1 -> exactly 2 strobes before ready rises; m_data_o held at first word; all 3 words delivered in order.
REQ-034 Empty mid-burst: empty=1 for 4 cycles after word 2 of len=5 -> strobe low for those cycles; 5 words total; no error.
REQ-035 Zero length: start with len=0 -> no strobe; done_o pulses the cycle after start; busy_o high for that one cycle.
REQ-036 Error and reset: fifo_error_i pulse in RUN -> err_o=1 until next start; rst asserted mid-burst -> all outputs at reset values next cycle, and no stale word appears on m_data_o.
REQ-037 With FIFO_READER_STATS_EN defined: 2 bursts of len 3 -> rd_count_o=3 after each burst.
